// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Purpose  : Shared types, widths and helpers for the keypad_scan block.
// Contents : key_state_t  - debounce FSM state encoding
//            CODE_W       - width of a key code (row*COLS+col)
//            CNT_W        - frame-counter width for the default parameter set
//            cnt_width()  - frame-counter width for any parameter set
//            onehot_low() - active-low single-row drive pattern
// Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } key_state_t;

  localparam int CODE_W = 4;

  // Width needed to count up to and including the larger of the two frame
  // thresholds. Modules call this with their own parameters.
  function automatic int cnt_width(input int debounce_scans, input int repeat_scans);
    int max_scans;
    max_scans = (debounce_scans > repeat_scans) ? debounce_scans : repeat_scans;
    return $clog2(max_scans + 1);
  endfunction

  localparam int CNT_W = cnt_width(2, 8);

  // Row drive pattern: every bit high except bit idx.
  function automatic logic [15:0] onehot_low(input logic [3:0] idx);
    return ~(16'h0001 << idx);
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_debounce_fsm.sv
`default_nettype none
// ============================================================================
// Module   : keypad_debounce_fsm
// Purpose  : Frame-level debounce of the scanned key code. Accepts a press
//            after DEBOUNCE_SCANS agreeing frames and a release after
//            DEBOUNCE_SCANS empty frames.
// Ports    : clk, rst (async, active-high), en (low idles the FSM)
//            frame_done - one-cycle strobe at the end of each scan frame
//            hit, code  - frame result (any key seen, highest-priority code)
//            key_code   - code of the last accepted press (held)
//            key_valid  - one-cycle pulse per accepted press
//            key_held   - high while the accepted key remains pressed
// Macro    : KEYPAD_REPEAT_EN - adds an auto-repeat key_valid every
//            REPEAT_SCANS hit frames while PRESSED.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_debounce_fsm
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 2,
  parameter int REPEAT_SCANS   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              frame_done,
  input  logic              hit,
  input  logic [CODE_W-1:0] code,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held
);

  localparam int                 c_cnt_w    = cnt_width(DEBOUNCE_SCANS, REPEAT_SCANS);
  localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_deb_last = c_cnt_w'(DEBOUNCE_SCANS);

  key_state_t          r_state;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [CODE_W-1:0]   r_cand;
  logic [c_cnt_w-1:0]  w_cnt_inc;

  assign w_cnt_inc = r_cnt + c_one;

`ifdef KEYPAD_REPEAT_EN
  localparam logic [c_cnt_w-1:0] c_rep_last = c_cnt_w'(REPEAT_SCANS);
  logic [c_cnt_w-1:0] r_rep;
  logic [c_cnt_w-1:0] w_rep_inc;
  assign w_rep_inc = r_rep + c_one;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_cand    <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rep     <= '0;
`endif
    end else if (!en) begin
      // key_code is deliberately kept so the last key survives a disable.
      r_state   <= IDLE;
      r_cnt     <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rep     <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      if (frame_done) begin
        case (r_state)
          IDLE: begin
            if (hit) begin
              r_state <= DEBOUNCE;
              r_cand  <= code;
              r_cnt   <= c_one;
            end
          end
          DEBOUNCE: begin
            if (!hit) begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end else if (code != r_cand) begin
              // A different key restarts the agreement count.
              r_cand <= code;
              r_cnt  <= c_one;
            end else if (w_cnt_inc == c_deb_last) begin
              r_state   <= PRESSED;
              r_cnt     <= '0;
              key_code  <= r_cand;
              key_valid <= 1'b1;
              key_held  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
              r_rep     <= '0;
`endif
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          PRESSED: begin
            if (!hit) begin
              r_state <= RELEASE;
              r_cnt   <= c_one;
`ifdef KEYPAD_REPEAT_EN
              r_rep   <= '0;
`endif
            end else begin
`ifdef KEYPAD_REPEAT_EN
              if (w_rep_inc == c_rep_last) begin
                key_valid <= 1'b1;
                r_rep     <= '0;
              end else begin
                r_rep <= w_rep_inc;
              end
`else
              // Any key, even a different one, keeps the press alive.
              r_state <= PRESSED;
`endif
            end
          end
          RELEASE: begin
            if (hit) begin
              // Short dropout while held: treat as bounce, no new event.
              r_state <= PRESSED;
              r_cnt   <= '0;
`ifdef KEYPAD_REPEAT_EN
              r_rep   <= '0;
`endif
            end else if (w_cnt_inc == c_deb_last) begin
              r_state  <= IDLE;
              r_cnt    <= '0;
              key_held <= 1'b0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan
// Purpose  : Row-scanned matrix keypad reader. Drives one row low at a time,
//            synchronizes and samples the active-low column returns, reduces
//            each full scan frame to (hit, code) and debounces over frames.
// Ports    : clk, rst (async, active-high)
//            en       - scan enable; low idles the block on the next edge
//            col_in   - column returns, active-low, asynchronous to clk
//            row_out  - row drive, active-low, at most one bit low
//            key_code - code of the accepted key, row*COLS+col
//            key_valid- one-cycle pulse per accepted press
//            key_held - high while the accepted key remains pressed
// Macro    : KEYPAD_REPEAT_EN - enables auto-repeat in the debounce FSM.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 2,
  parameter int REPEAT_SCANS   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [COLS-1:0]   col_in,
  output logic [ROWS-1:0]   row_out,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held
);

  localparam int                 c_div_w    = $clog2(SCAN_DIV);
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCAN_DIV - 1);
  localparam logic [3:0]         c_row_last = 4'(ROWS - 1);

  logic [COLS-1:0]    r_col_s1;
  logic [COLS-1:0]    r_col_s2;
  logic [c_div_w-1:0] r_div;
  logic [3:0]         r_row_idx;
  logic               r_acc_hit;
  logic [CODE_W-1:0]  r_acc_code;
  logic               r_frame_done;
  logic               r_frame_hit;
  logic [CODE_W-1:0]  r_frame_code;

  logic               w_tick;
  logic               w_last_row;
  logic [3:0]         w_row_next;
  logic               w_row_hit;
  logic [3:0]         w_col_sel;
  logic [CODE_W-1:0]  w_row_code;

  // Two-flop synchronizer; idles high (no key) out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col_s1 <= '1;
      r_col_s2 <= '1;
    end else begin
      r_col_s1 <= col_in;
      r_col_s2 <= r_col_s1;
    end
  end

  assign w_tick     = en && (r_div == c_div_last);
  assign w_last_row = (r_row_idx == c_row_last);
  assign w_row_next = w_tick ? (w_last_row ? 4'd0 : r_row_idx + 4'd1) : r_row_idx;

  // Lowest pressed column of the row currently being driven. Rows are
  // visited in ascending order, so the first hit in a frame also has the
  // lowest row.
  always_comb begin
    w_row_hit = 1'b0;
    w_col_sel = 4'd0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!r_col_s2[c]) begin
        w_row_hit = 1'b1;
        w_col_sel = 4'(c);
      end
    end
    w_row_code = CODE_W'(int'(r_row_idx) * COLS + int'(w_col_sel));
  end

  // Divider, row stepping and per-frame accumulation. row_out is computed
  // from the next row index so the drive and the index always agree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div        <= '0;
      r_row_idx    <= '0;
      row_out      <= '1;
      r_acc_hit    <= 1'b0;
      r_acc_code   <= '0;
      r_frame_done <= 1'b0;
      r_frame_hit  <= 1'b0;
      r_frame_code <= '0;
    end else if (!en) begin
      r_div        <= '0;
      r_row_idx    <= '0;
      row_out      <= '1;
      r_acc_hit    <= 1'b0;
      r_acc_code   <= '0;
      r_frame_done <= 1'b0;
      r_frame_hit  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_div        <= (r_div == c_div_last) ? '0 : r_div + 1'b1;
      r_row_idx    <= w_row_next;
      row_out      <= ROWS'(onehot_low(w_row_next));
      if (w_tick) begin
        if (w_last_row) begin
          r_frame_done <= 1'b1;
          r_frame_hit  <= r_acc_hit | w_row_hit;
          r_frame_code <= r_acc_hit ? r_acc_code : w_row_code;
          r_acc_hit    <= 1'b0;
          r_acc_code   <= '0;
        end else if (!r_acc_hit && w_row_hit) begin
          r_acc_hit  <= 1'b1;
          r_acc_code <= w_row_code;
        end
      end
    end
  end

  keypad_debounce_fsm #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
    .REPEAT_SCANS   (REPEAT_SCANS)
  ) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .frame_done (r_frame_done),
    .hit        (r_frame_hit),
    .code       (r_frame_code),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_held   (key_held)
  );

endmodule
`default_nettype wire
